// File: rtl/prng_lut_pkg.sv
// Shared types and the quantised epsilon table for the multi-channel epsilon PRNG.
// Every channel indexes EPS_LUT with its current state value.
package prng_lut_pkg;

  typedef enum logic {
    MODE_XSA  = 1'b0,
    MODE_LFSR = 1'b1
  } mode_e;

  localparam logic [0:0] ST_UNSEEDED = 1'b0;
  localparam logic [0:0] ST_RUN      = 1'b1;

  localparam int LUT_DEPTH = 32;

  // Monotone decay from 1.0 (Q.10) down to zero; the top two slots are hard zero.
  localparam logic [15:0] EPS_LUT [0:LUT_DEPTH-1] = '{
    16'h0400, 16'h0400, 16'h03E0, 16'h03C0, 16'h03A0, 16'h0380, 16'h0360, 16'h0340,
    16'h0320, 16'h0300, 16'h02E0, 16'h02C0, 16'h02A0, 16'h0280, 16'h0260, 16'h0240,
    16'h0220, 16'h0200, 16'h01F0, 16'h01E0, 16'h01C7, 16'h01A0, 16'h0180, 16'h0155,
    16'h0130, 16'h0110, 16'h00F0, 16'h00D0, 16'h00A0, 16'h0071, 16'h0000, 16'h0000
  };

endpackage

// File: rtl/prng_lut_multi_if.sv
// Control and sample bus of the multi-channel epsilon PRNG.
// Channel c of seed/state_dbg/out_data sits at row [c] (same bit layout as [c*W +: W]).
interface prng_lut_multi_if #(
  parameter int NUM_CH  = 4,
  parameter int STATE_W = 5,
  parameter int OUT_W   = 16,
  parameter int CNT_W   = 16
);
  logic                             mode;
  logic                             seed_load;
  logic [NUM_CH-1:0][STATE_W-1:0]   seed;
  logic                             out_valid;
  logic                             out_ready;
  logic [NUM_CH-1:0][OUT_W-1:0]     out_data;
  logic [NUM_CH-1:0][STATE_W-1:0]   state_dbg;
  logic [CNT_W-1:0]                 sample_cnt;

  modport master (
    output mode, seed_load, seed, out_ready,
    input  out_valid, out_data, state_dbg, sample_cnt
  );

  modport slave (
    input  mode, seed_load, seed, out_ready,
    output out_valid, out_data, state_dbg, sample_cnt
  );
endinterface

// File: rtl/prng_lut_ch.sv
// One PRNG channel: state register, xorshift-add / Galois LFSR step, epsilon LUT read.
// PRNG_SIGN_EN: negate the sample when the new state has odd parity.
module prng_lut_ch
  import prng_lut_pkg::*;
#(
  parameter int                 STATE_W = 5,
  parameter int                 OUT_W   = 16,
  parameter int                 SHIFT   = 4,
  parameter int                 INC     = 3,
  parameter logic [STATE_W-1:0] TAPS    = 5'b10100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               adv,
  input  mode_e              mode,
  input  logic [STATE_W-1:0] seed,
  output logic [STATE_W-1:0] state,
  output logic [OUT_W-1:0]   data
);

  logic [STATE_W-1:0] shl, xsa_next, lfsr_next, seed_eff, nxt_state;
  logic [OUT_W-1:0]   lut_val, nxt_data;

  always_comb begin
    shl      = state << SHIFT;
    xsa_next = (state ^ shl) + STATE_W'(INC);

    // Zero is a lock-up state for the LFSR; it can appear after a mode switch.
    if (state == '0)
      lfsr_next = STATE_W'(1);
    else if (state[0])
      lfsr_next = (state >> 1) ^ TAPS;
    else
      lfsr_next = state >> 1;

    seed_eff = ((mode == MODE_LFSR) && (seed == '0)) ? STATE_W'(1) : seed;

    if (load)
      nxt_state = seed_eff;
    else if (mode == MODE_LFSR)
      nxt_state = lfsr_next;
    else
      nxt_state = xsa_next;

    lut_val = OUT_W'(EPS_LUT[nxt_state]);
`ifdef PRNG_SIGN_EN
    nxt_data = (^nxt_state) ? (~lut_val + OUT_W'(1)) : lut_val;
`else
    nxt_data = lut_val;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= '0;
      data  <= '0;
    end else if (load || adv) begin
      state <= nxt_state;
      data  <= nxt_data;
    end
  end

endmodule

// File: rtl/prng_lut_multi.sv
// Multi-channel epsilon PRNG top: seed/run FSM, valid/ready handshake, accepted-set counter.
// Optional PRNG_SIGN_EN signs samples by state parity (inside prng_lut_ch).
module prng_lut_multi
  import prng_lut_pkg::*;
#(
  parameter int                 NUM_CH  = 4,
  parameter int                 STATE_W = 5,
  parameter int                 OUT_W   = 16,
  parameter int                 SHIFT   = 4,
  parameter int                 INC     = 3,
  parameter logic [STATE_W-1:0] TAPS    = 5'b10100,
  parameter int                 CNT_W   = 16
) (
  input logic              clk,
  input logic              rst_n,
  prng_lut_multi_if.slave  bus
);

  logic [0:0]       fsm;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept, adv;
  mode_e            mode;

  assign mode   = mode_e'(bus.mode);
  // Ready is meaningless before the first seed, so accept is gated by RUN.
  assign accept = valid_q && bus.out_ready && (fsm == ST_RUN);
  // A simultaneous seed load still consumes the current set but owns the state update.
  assign adv    = accept && !bus.seed_load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm     <= ST_UNSEEDED;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (bus.seed_load) begin
        fsm     <= ST_RUN;
        valid_q <= 1'b1;
      end
      if (accept)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_ch
      prng_lut_ch #(
        .STATE_W (STATE_W),
        .OUT_W   (OUT_W),
        .SHIFT   (SHIFT),
        .INC     (INC),
        .TAPS    (TAPS)
      ) u_ch (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (bus.seed_load),
        .adv   (adv),
        .mode  (mode),
        .seed  (bus.seed[c]),
        .state (bus.state_dbg[c]),
        .data  (bus.out_data[c])
      );
    end
  endgenerate

  assign bus.out_valid  = valid_q;
  assign bus.sample_cnt = cnt_q;

endmodule

// File: tb/tb_prng_lut_multi.sv
// Scoreboard bench: stimulus pushes the expected post-edge view, a negedge monitor pops and compares.
module tb_prng_lut_multi;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  prng_lut_multi_if #(.NUM_CH(4), .STATE_W(5), .OUT_W(16), .CNT_W(16)) bus ();

  prng_lut_multi dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        vld;
    logic [63:0] data;
    logic [19:0] st;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Independent copy of the epsilon table.
  logic [15:0] lut [0:31] = '{
    16'h0400, 16'h0400, 16'h03E0, 16'h03C0, 16'h03A0, 16'h0380, 16'h0360, 16'h0340,
    16'h0320, 16'h0300, 16'h02E0, 16'h02C0, 16'h02A0, 16'h0280, 16'h0260, 16'h0240,
    16'h0220, 16'h0200, 16'h01F0, 16'h01E0, 16'h01C7, 16'h01A0, 16'h0180, 16'h0155,
    16'h0130, 16'h0110, 16'h00F0, 16'h00D0, 16'h00A0, 16'h0071, 16'h0000, 16'h0000
  };

  // Reference model state
  int          m_st [4];
  logic [15:0] m_dat [4];
  logic        m_vld, m_run;
  logic [15:0] m_cnt;

  function automatic logic [15:0] sample(input int s);
    logic [15:0] v;
    v = lut[s];
`ifdef PRNG_SIGN_EN
    if ($countones(s[4:0]) % 2 == 1) v = 16'h0000 - v;
`endif
    return v;
  endfunction

  function automatic int next_st(input int s, input logic m);
    if (m) begin
      if (s == 0) return 1;
      return (s % 2 == 1) ? ((s / 2) ^ 20) : (s / 2);
    end
    return ((s ^ ((s * 16) % 32)) + 3) % 32;
  endfunction

  function automatic logic [19:0] pk(input int s0, input int s1, input int s2, input int s3);
    logic [4:0] a, b, c, d;
    a = 5'(s0); b = 5'(s1); c = 5'(s2); d = 5'(s3);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock: drive inputs at negedge, step the model after the posedge, queue the expected view.
  task automatic cyc(input logic r, input logic m, input logic ld, input logic [19:0] sd, input logic rdy);
    logic acc;
    int   s;
    exp_t e;
    @(negedge clk);
    rst_n = r; bus.mode = m; bus.seed_load = ld; bus.seed = sd; bus.out_ready = rdy;
    @(posedge clk);
    if (!r) begin
      for (int c = 0; c < 4; c++) begin m_st[c] = 0; m_dat[c] = 16'h0; end
      m_vld = 1'b0; m_run = 1'b0; m_cnt = 16'h0;
    end else begin
      acc = m_vld && rdy && m_run;
      if (acc) m_cnt = m_cnt + 16'h1;
      if (ld) begin
        for (int c = 0; c < 4; c++) begin
          s = int'(sd[c*5 +: 5]);
          if (m && s == 0) s = 1;
          m_st[c] = s; m_dat[c] = sample(s);
        end
        m_vld = 1'b1; m_run = 1'b1;
      end else if (acc) begin
        for (int c = 0; c < 4; c++) begin
          m_st[c] = next_st(m_st[c], m);
          m_dat[c] = sample(m_st[c]);
        end
      end
    end
    e.vld  = m_vld;
    e.data = {m_dat[3], m_dat[2], m_dat[1], m_dat[0]};
    e.st   = pk(m_st[0], m_st[1], m_st[2], m_st[3]);
    e.cnt  = m_cnt;
    q.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_valid",  64'(bus.out_valid),  64'(e.vld));
        chk("out_data",   bus.out_data,        e.data);
        chk("state_dbg",  64'(bus.state_dbg),  64'(e.st));
        chk("sample_cnt", 64'(bus.sample_cnt), 64'(e.cnt));
      end
    end
  end

  initial begin
    int wait_cyc;
    rst_n = 1'b0; bus.mode = 1'b0; bus.seed_load = 1'b0; bus.seed = '0; bus.out_ready = 1'b0;

    cyc(0, 0, 0, 20'h0, 0);
    cyc(0, 0, 0, 20'h0, 0);
    cyc(1, 0, 0, 20'h0, 1);                       // unseeded: ready ignored
    cyc(1, 0, 1, pk(1, 7, 13, 30), 0);            // seed -> samples next cycle
    repeat (2) cyc(1, 0, 0, 20'h0, 1);            // ch0 1 -> 20 -> 23
    repeat (5) cyc(1, 0, 0, 20'h0, 0);            // stall
    repeat (4) cyc(1, 0, 0, 20'h0, 1);            // resume
    cyc(1, 1, 1, pk(0, 0, 0, 0), 0);              // LFSR seed 0 forced to 1
    repeat (31) cyc(1, 1, 0, 20'h0, 1);
    cyc(1, 0, 1, pk(13, 3, 0, 31), 0);
    cyc(1, 0, 0, 20'h0, 1);                       // ch0 13 -> 0
    repeat (2) cyc(1, 1, 0, 20'h0, 1);            // mode switch, 0 -> 1 -> 20
    cyc(1, 0, 1, pk(3, 1, 20, 23), 1);            // seed + accept together
    cyc(1, 0, 0, 20'h0, 1);
    cyc(0, 0, 0, 20'h0, 1);                       // reset mid-run
    repeat (2) cyc(1, 0, 0, 20'h0, 1);
    cyc(1, 0, 1, pk(1, 3, 5, 6), 0);              // parity 1 / 0 samples
    repeat (2) cyc(1, 0, 0, 20'h0, 1);

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d pending required=0", q.size());
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
